// File: rtl/ddr_rx_gearbox_pkg.sv
// ddr_rx_gearbox_pkg
//   Shared types and helpers for the DDR receive gearbox.
//   - rx_state_e : capture FSM state encoding
//   - fifo_aw    : address width of the output FIFO for a given depth
package ddr_rx_gearbox_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_CAPT = 2'd2
    } rx_state_e;

    // Address bits for a power-of-two FIFO; pointers carry one extra wrap bit.
    function automatic int fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ddr_rx_gearbox_if.sv
// ddr_rx_gearbox_if
//   Output word stream of the gearbox.
//   out_data  : FIFO head word (registered)
//   out_valid : FIFO non-empty
//   out_ready : consumer pop
//   Handshake: a word transfers on a posedge where out_valid & out_ready are both
//   high; while out_valid is high and out_ready low, out_data holds its value.
//   master = gearbox side, slave = consumer side.
interface ddr_rx_gearbox_if #(
    parameter int DW = 32
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ddr_rx_fifo.sv
// ddr_rx_fifo
//   Synchronous FIFO with a registered head word.
//   clk, reset_n : clock, async active-low reset
//   flush        : empty the FIFO at the next edge
//   push         : write push_data (ignored when wr_full)
//   push_data    : word to write
//   wr_full      : FIFO cannot take a word this cycle (pop already accounted for)
//   out_if       : head word / valid / ready towards the consumer
module ddr_rx_fifo
    import ddr_rx_gearbox_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DW-1:0]     push_data,
    output logic              wr_full,
    ddr_rx_gearbox_if.master  out_if
);
    localparam int AW = fifo_aw(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   rptr_nx;
    logic [AW:0]   count;
    logic          pop;
    logic          do_write;
    logic [DW-1:0] head_q;
    logic          valid_q;

    assign pop      = valid_q & out_if.out_ready;
    assign count    = wptr - rptr;
    assign rptr_nx  = pop ? rptr + (AW + 1)'(1) : rptr;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign wr_full  = (count == (AW + 1)'(DEPTH)) && !pop;
    assign do_write = push && !wr_full;

    // The head register looks at the pre-edge write pointer, so a word becomes
    // visible one edge after it is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + (AW + 1)'(1);
            end
            rptr    <= rptr_nx;
            valid_q <= (wptr != rptr_nx);
            head_q  <= mem[rptr_nx[AW-1:0]];
        end
    end

    assign out_if.out_data  = head_q;
    assign out_if.out_valid = valid_q;

endmodule

// File: rtl/ddr_rx_gearbox.sv
// ddr_rx_gearbox
//   DDR pad capture, dummy-cycle wait and word packing for the OSPI-SRAM read path.
//   clk, reset_n : clock (pads sampled on both edges), async active-low reset
//   pad_i        : DDR pad data
//   fall_first   : 0 pair = {rise,fall}; 1 pair = {fall,next rise}
//   start        : begin a burst (IDLE only); lat/len sampled with it
//   abort        : back to IDLE, flush FIFO, drop partial word
//   busy         : FSM not idle
//   done         : 1-cycle pulse after the last word of a burst is written
//   overflow     : sticky, a word was dropped on a full FIFO
//   dbg_state    : current FSM state
//   out_if       : packed words (valid/ready)
module ddr_rx_gearbox
    import ddr_rx_gearbox_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PAIRS      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT_W      = 5,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  pad_i,
    input  logic              fall_first,
    input  logic              start,
    input  logic              abort,
    input  logic [LAT_W-1:0]  lat,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output rx_state_e         dbg_state,
    ddr_rx_gearbox_if.master  out_if
);
    localparam int PW   = 2 * WIDTH;
    localparam int DW   = PAIRS * PW;
    localparam int PI_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    rx_state_e        state, state_nx;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic [PW-1:0]    pair;
    logic [LAT_W-1:0] lat_cnt;
    logic [LEN_W-1:0] len_q, word_cnt;
    logic [PI_W-1:0]  pair_idx;
    logic [DW-1:0]    word_q, push_word;
    logic             last_pair, last_word, start_acc;
    logic             push, done_set, wr_full;
    logic             done_q, overflow_q;

    // Edge capture; the earlier beat of each pair goes in the low half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rise_q <= '0;
        else          rise_q <= pad_i;
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) fall_q <= '0;
        else          fall_q <= pad_i;
    end

    assign pair = fall_first ? {pad_i, fall_q} : {fall_q, rise_q};

    assign last_pair = (pair_idx == PI_W'(PAIRS - 1));
    assign last_word = (word_cnt == len_q - LEN_W'(1));
    assign start_acc = (state == RX_IDLE) && start && !abort;

    // The completing pair goes straight into the pushed word.
    always_comb begin
        push_word = word_q;
        push_word[(PAIRS - 1) * PW +: PW] = pair;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RX_IDLE;
        else          state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: if (start && len != '0) state_nx = (lat == '0) ? RX_CAPT : RX_WAIT;
                RX_WAIT: if (lat_cnt == LAT_W'(1)) state_nx = RX_CAPT;
                RX_CAPT: if (last_pair && last_word) state_nx = RX_IDLE;
                default: state_nx = RX_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy      = (state != RX_IDLE);
        dbg_state = state;
        push      = (state == RX_CAPT) && last_pair && !abort;
        done_set  = (push && last_word) || (start_acc && len == '0);
    end

    // Counters and packer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt  <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            pair_idx <= '0;
            word_q   <= '0;
        end else if (abort) begin
            lat_cnt  <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            pair_idx <= '0;
            word_q   <= '0;
        end else begin
            case (state)
                RX_IDLE: if (start) begin
                    lat_cnt  <= lat;
                    len_q    <= len;
                    word_cnt <= '0;
                    pair_idx <= '0;
                end
                RX_WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
                RX_CAPT: begin
                    word_q[int'(pair_idx) * PW +: PW] <= pair;
                    if (last_pair) begin
                        pair_idx <= '0;
                        word_cnt <= word_cnt + LEN_W'(1);
                    end else begin
                        pair_idx <= pair_idx + PI_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A dropped word still counts toward len, so overflow does not stall the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= done_set;
            if (start_acc)             overflow_q <= 1'b0;
            else if (push && wr_full)  overflow_q <= 1'b1;
        end
    end

    assign done     = done_q;
    assign overflow = overflow_q;

    ddr_rx_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (push),
        .push_data (push_word),
        .wr_full   (wr_full),
        .out_if    (out_if)
    );

endmodule

// File: tb/tb_ddr_rx_gearbox.sv
module tb_ddr_rx_gearbox;
    import ddr_rx_gearbox_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pad_i;
    logic        fall_first;
    logic        start;
    logic        abort;
    logic [4:0]  lat;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        overflow;
    rx_state_e   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int exp_done = 0;

    ddr_rx_gearbox_if #(.DW(32)) rx_if ();

    ddr_rx_gearbox #(
        .WIDTH(8), .PAIRS(2), .FIFO_DEPTH(4), .LAT_W(5), .LEN_W(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pad_i      (pad_i),
        .fall_first (fall_first),
        .start      (start),
        .abort      (abort),
        .lat        (lat),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .dbg_state  (dbg_state),
        .out_if     (rx_if)
    );

    // clock: period 10, posedge at 5, 15, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // done pulse counter and backpressure stability check, sampled at negedge
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (prev_hold && rx_if.out_valid === 1'b1)
                chk("stable_under_backpressure", rx_if.out_data, prev_data);
            prev_hold = rx_if.out_valid & ~rx_if.out_ready;
            prev_data = rx_if.out_data;
        end
    end

    // Issue start at edge t, then drive pads so that rise of cycle t+lat is 0x01,
    // its fall 0x02, and so on; returns 2 time units after the last pair edge.
    task automatic run_burst(input logic ff, input int lat_i, input int len_i);
        int npairs;
        npairs = len_i * 2;
        fall_first = ff;
        lat   = 5'(lat_i);
        len   = 8'(len_i);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 1; k <= lat_i + npairs; k++) begin
            @(negedge clk); #2;
            pad_i = (k >= lat_i) ? 8'(2 * (k - lat_i) + 1) : 8'hEE;
            @(posedge clk); #2;
            pad_i = (k >= lat_i) ? 8'(2 * (k - lat_i) + 2) : 8'hEE;
        end
    endtask

    task automatic pop_one();
        @(posedge clk); #2;
        rx_if.out_ready = 1'b1;
        @(posedge clk); #2;
        rx_if.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        pad_i = 8'h00; fall_first = 1'b0; start = 1'b0; abort = 1'b0;
        lat = '0; len = '0; rx_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        chk("reset_valid", 32'(rx_if.out_valid), 32'h0);
        chk("reset_data", rx_if.out_data, 32'h0);
        @(posedge clk); #2;

        // 1: rise-first, lat 3, len 2
        run_burst(1'b0, 3, 2);
        exp_done++;
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_after", 32'(busy), 32'h0);
        @(posedge clk); @(negedge clk);
        chk("t1_done_cleared", 32'(done), 32'h0);
        chk("t1_valid", 32'(rx_if.out_valid), 32'h1);
        chk("t1_word0", rx_if.out_data, 32'h04030201);
        pop_one();
        chk("t1_word1", rx_if.out_data, 32'h08070605);
        pop_one();
        chk("t1_empty", 32'(rx_if.out_valid), 32'h0);

        // 2: fall-first, same stimulus
        @(posedge clk); #2;
        run_burst(1'b1, 3, 2);
        exp_done++;
        chk("t2_done", 32'(done), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("t2_word0", rx_if.out_data, 32'h05040302);
        pop_one();
        chk("t2_word1", rx_if.out_data, 32'h09080706);
        pop_one();
        chk("t2_empty", 32'(rx_if.out_valid), 32'h0);

        // 3: len 0 -> done next cycle, never busy
        @(posedge clk); #2;
        fall_first = 1'b0; lat = 5'd2; len = 8'd0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        exp_done++;
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0);
        @(posedge clk); #2;
        chk("t3_done_cleared", 32'(done), 32'h0);
        chk("t3_busy2", 32'(busy), 32'h0);
        chk("t3_valid", 32'(rx_if.out_valid), 32'h0);

        // 4: overflow with out_ready low, depth 4, len 6
        run_burst(1'b0, 1, 6);
        exp_done++;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_overflow", 32'(overflow), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("t4_word0", rx_if.out_data, 32'h04030201);
        pop_one();
        chk("t4_word1", rx_if.out_data, 32'h08070605);
        pop_one();
        chk("t4_word2", rx_if.out_data, 32'h0C0B0A09);
        pop_one();
        chk("t4_word3", rx_if.out_data, 32'h100F0E0D);
        pop_one();
        chk("t4_dropped", 32'(rx_if.out_valid), 32'h0);
        chk("t4_overflow_sticky", 32'(overflow), 32'h1);

        // 5: abort after one captured pair; start clears overflow
        @(posedge clk); #2;
        fall_first = 1'b0; lat = 5'd1; len = 8'd2; start = 1'b1; pad_i = 8'hA5;
        @(posedge clk); #2;
        start = 1'b0;
        chk("t5_overflow_cleared", 32'(overflow), 32'h0);
        @(posedge clk);
        @(posedge clk); #2;
        chk("t5_busy_capt", 32'(busy), 32'h1);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("t5_idle", 32'(busy), 32'h0);
        chk("t5_valid", 32'(rx_if.out_valid), 32'h0);
        chk("t5_no_done", 32'(done), 32'h0);
        run_burst(1'b0, 2, 1);
        exp_done++;
        chk("t5_clean_done", 32'(done), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("t5_clean_word", rx_if.out_data, 32'h04030201);

        // 6: reset mid-WAIT with a word still held in the FIFO
        @(posedge clk); #2;
        fall_first = 1'b0; lat = 5'd5; len = 8'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #3;
        chk("t6_busy_wait", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_valid", 32'(rx_if.out_valid), 32'h0);
        chk("t6_rst_data", rx_if.out_data, 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        run_burst(1'b1, 2, 1);
        exp_done++;
        chk("t6_done", 32'(done), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("t6_word", rx_if.out_data, 32'h05040302);
        pop_one();
        chk("t6_empty", 32'(rx_if.out_valid), 32'h0);

        @(posedge clk); @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
